mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the fetch requester (instruction read) and the memory-unit requester (data load/store).
- Sits between the core's fetch/mem-stage interfaces and the single external memory bus.
- Latches the granted request, holds the downstream port stable until `m_resp`, then routes data and the response back to the owner.
- Fixed data-first priority, with an anti-starvation streak limit for fetch and a sticky watchdog flag.

Parameters:
- `MAX_STREAK`, 4: max consecutive data grants while a fetch is waiting; then fetch wins the next contested arbitration. Range 1..15.
- `TIMEOUT`, 255: busy-cycle count at which `timeout_err` sets; 0 disables the watchdog. Range 0..255.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `i_read`  in  1  fetch request; held until `i_resp`
- `i_addr`  in  32  fetch address
- `i_rdata`  out  32  fetch read data, valid with `i_resp`
- `i_resp`  out  1  one-cycle fetch completion pulse
- `d_read`  in  1  data load request; held until `d_resp`
- `d_write`  in  1  data store request; held until `d_resp`
- `d_addr`  in  32  data address
- `d_wdata`  in  32  store data
- `d_mbe`  in  4  store byte enable
- `d_rdata`  out  32  load data, valid with `d_resp`
- `d_resp`  out  1  one-cycle data completion pulse
- `m_read`  out  1  downstream read strobe
- `m_write`  out  1  downstream write strobe
- `m_addr`  out  32  downstream address
- `m_wdata`  out  32  downstream write data
- `m_mbe`  out  4  downstream byte enable
- `m_rdata`  in  32  downstream read data
- `m_resp`  in  1  downstream completion
- `busy`  out  1  high when the FSM is not IDLE
- `timeout_err`  out  1  sticky watchdog flag

Behaviour:
- **Reset (async, immediate):**
  - state = IDLE; latched address/wdata/mbe/op = 0; streak = 0; watchdog = 0; `timeout_err` = 0.
  - All outputs are 0, and `m_read`/`m_write` drop in the same instant even mid-transaction.
- **FSM states:** IDLE, BUSY_I, BUSY_D.
- **IDLE:**
  - Sample requests. `d_req = d_read | d_write`.
  - Grant selection:
    - Only `i_read` → BUSY_I.
    - Only `d_req` → BUSY_D.
    - Both, with streak < `MAX_STREAK` → BUSY_D.
    - Both, with streak == `MAX_STREAK` → BUSY_I.
    - None → stay in IDLE.
  - On the grant edge, latch addr/wdata/mbe/op from the winner.
  - Fetch op = read, mbe = 4'hF, wdata = 0.
  - Data op: write if `d_write`, else read. `d_write` wins if both `d_read` and `d_write` are high.
- **Streak counter:**
  - On a BUSY_D grant with `i_read` high: increment, saturating at `MAX_STREAK`.
  - On a BUSY_D grant with `i_read` low, or on any BUSY_I grant: clear to 0.
- **BUSY_x:**
  - `m_*` are driven only from the latched registers, so requester input changes are ignored.
  - `m_read` = latched op read; `m_write` = latched op write.
- **Completion:**
  - On `m_resp` in BUSY_I: `i_resp` = 1 and `i_rdata` = `m_rdata`, combinationally in the same cycle. Next state is IDLE.
  - BUSY_D is the same via `d_resp`/`d_rdata`. `d_rdata` passes through on stores too; the requester ignores it.
- **Outputs outside a response:**
  - `i_rdata`/`d_rdata` = 0 when their resp is low.
  - `m_wdata`/`m_mbe`/`m_addr` = 0 in IDLE.
- **Latency:**
  - Request seen in cycle N → `m_*` asserted in cycle N+1 → resp in the cycle `m_resp` arrives (earliest N+1).
  - Back-to-back: minimum 2 cycles per transaction, because IDLE always lasts ≥1 cycle. The requester has deasserted by then, so there is no duplicate grant.
- **Spurious `m_resp` in IDLE:** ignored; no resp is forwarded.
- **Watchdog:**
  - 8-bit counter clears on entering BUSY_x and increments each BUSY cycle without `m_resp`.
  - When the counter equals `TIMEOUT` (and `TIMEOUT` != 0), `timeout_err` is set and stays set until `rst`.
  - The transaction keeps waiting; there is no abort.
- **`busy`:** equals (state != IDLE).

Decomposition:
- **Shared package (`rv32i_types`):**
  - enum `mem_arb_state_t` {IDLE, BUSY_I, BUSY_D}
  - enum `mem_arb_op_t` {rd, wr}
  - constant `MEM_ARB_WDOG_BITS` = 8
- **Sub-module `mem_arb_pick`:**
  - Combinational grant selector.
  - Inputs: `i_read`, `d_req`, `streak_full`.
  - Outputs: `grant_i`, `grant_d`.
  - Isolates the priority policy for later round-robin replacement.
- **Everything else stays in the top:** FSM, latches, streak, watchdog.

Test Plan:
- Lone fetch: `i_read`=1, `i_addr`=0x0000_0040 at cycle 0; `m_resp`=1, `m_rdata`=0xDEAD_BEEF at cycle 3 → `m_read`=1 and `m_addr`=0x40 from cycle 1; `i_resp`=1 and `i_rdata`=0xDEADBEEF in cycle 3; `busy`=0 in cycle 4.
- Store: `d_write`=1, addr 0x100, wdata 0x1234_5678, mbe 4'b0011, `m_resp` after 1 cycle → `m_write`=1, `m_wdata`=0x12345678, `m_mbe`=0011 in cycle 1; `d_resp`=1 in cycle 1; `i_resp` stays 0.
- Contention/starvation: `i_read` and `d_read` held high continuously, `MAX_STREAK`=4, `m_resp` every busy cycle → grant sequence D,D,D,D,I; fetch is serviced on the 5th grant.
- Input change mid-transaction: after the BUSY_D grant, change `d_addr` to 0x200 before `m_resp` → `m_addr` stays at the latched 0x100.
- Async reset mid-transaction: assert `rst` between clock edges during BUSY_I → `m_read`/`busy` go to 0 immediately; after release with `i_read` still high, a new grant occurs 1 cycle later.
- Watchdog: `TIMEOUT`=5, `m_resp` withheld → `timeout_err`=1 after 5 busy cycles, remains 1 after a later `m_resp`, clears only on `rst`.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   mem_arb_state_t   : arbiter FSM states
//   mem_arb_op_t      : latched downstream operation
//   MEM_ARB_WDOG_BITS : width of the busy-cycle watchdog counter
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    rd = 1'b0,
    wr = 1'b1
  } mem_arb_op_t;

  localparam int MEM_ARB_WDOG_BITS = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around the
// arbiter.
//   slave  : arbiter view (takes requests, drives responses and m_*)
//   master : environment view (cores and memory model)
interface mem_port_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mbe;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_mbe;
  logic [31:0] m_rdata;
  logic        m_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_mbe,
    input  m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output m_read, m_write, m_addr, m_wdata, m_mbe
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_mbe,
    output m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  m_read, m_write, m_addr, m_wdata, m_mbe
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: data first, unless fetch has been starved
// for a full streak of data grants.
//   i_read      : fetch request
//   d_req       : data request (load or store)
//   streak_full : data has won MAX_STREAK contested grants in a row
//   grant_i/d   : one-hot (or none) grant
module mem_arb_pick (
  input  logic i_read,
  input  logic d_req,
  input  logic streak_full,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & (~i_read | ~streak_full);
  assign grant_i = i_read & (~d_req | streak_full);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters. The winning
// request is latched at grant and held on m_* until m_resp, which is routed
// combinationally back to the owner.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : fetch/data/memory handshakes (slave view)
//   busy         : FSM not IDLE
//   timeout_err  : sticky watchdog flag
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                timeout_err
);

  localparam int STREAK_W = 4;
  localparam int WDOG_W   = MEM_ARB_WDOG_BITS;
  localparam logic [WDOG_W-1:0] TMO = WDOG_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_BUSY_I = BUSY_I;
  localparam logic [1:0] ST_BUSY_D = BUSY_D;

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          mbe_q, mbe_d;
  mem_arb_op_t         op_q, op_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                err_q, err_d;

  logic d_req, streak_full, grant_i, grant_d;

  assign d_req       = bus.d_read | bus.d_write;
  assign streak_full = (streak_q == STREAK_W'(MAX_STREAK));

  mem_arb_pick u_pick (
    .i_read      (bus.i_read),
    .d_req       (d_req),
    .streak_full (streak_full),
    .grant_i     (grant_i),
    .grant_d     (grant_d)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mbe_d    = mbe_q;
    op_d     = op_q;
    streak_d = streak_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          state_d  = ST_BUSY_I;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          mbe_d    = 4'hF;
          op_d     = rd;
          streak_d = '0;
          wdog_d   = '0;
        end else if (grant_d) begin
          state_d  = ST_BUSY_D;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          mbe_d    = bus.d_mbe;
          op_d     = bus.d_write ? wr : rd;
          // Only grants that made a waiting fetch lose count toward the streak.
          if (bus.i_read) begin
            if (!streak_full) streak_d = streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
          wdog_d   = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.m_resp) begin
          state_d = ST_IDLE;
        end else begin
          if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
          // Flag raises on the same edge the counter reaches the limit.
          if ((TIMEOUT != 0) && (wdog_d == TMO)) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mbe_q    <= '0;
      op_q     <= rd;
      streak_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mbe_q    <= mbe_d;
      op_q     <= op_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

  // Downstream port is driven purely from the latches while busy.
  assign bus.m_read  = busy && (op_q == rd);
  assign bus.m_write = busy && (op_q == wr);
  assign bus.m_addr  = busy ? addr_q  : '0;
  assign bus.m_wdata = busy ? wdata_q : '0;
  assign bus.m_mbe   = busy ? mbe_q   : '0;

  assign bus.i_resp  = (state_q == ST_BUSY_I) && bus.m_resp;
  assign bus.d_resp  = (state_q == ST_BUSY_D) && bus.m_resp;
  assign bus.i_rdata = bus.i_resp ? bus.m_rdata : '0;
  assign bus.d_rdata = bus.d_resp ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic busy;
  logic timeout_err;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MAX_STREAK (4),
    .TIMEOUT    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_read;
    logic [31:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mbe;
    logic [31:0] m_rdata;
    logic        m_resp;
    logic        e_m_read;
    logic        e_m_write;
    logic [31:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic [3:0]  e_m_mbe;
    logic        e_i_resp;
    logic [31:0] e_i_rdata;
    logic        e_d_resp;
    logic [31:0] e_d_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs [15];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.i_read  = 1'b0; bus.i_addr  = '0;
    bus.d_read  = 1'b0; bus.d_write = 1'b0;
    bus.d_addr  = '0;   bus.d_wdata = '0; bus.d_mbe = '0;
    bus.m_rdata = '0;   bus.m_resp  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m_read"},  32'(bus.m_read),  32'd0);
    check({tag, ".m_write"}, 32'(bus.m_write), 32'd0);
    check({tag, ".m_addr"},  bus.m_addr,       32'd0);
    check({tag, ".i_resp"},  32'(bus.i_resp),  32'd0);
    check({tag, ".d_resp"},  32'(bus.d_resp),  32'd0);
    check({tag, ".busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    // {i_read,i_addr,d_read,d_write,d_addr,d_wdata,d_mbe,m_rdata,m_resp,
    //  m_read,m_write,m_addr,m_wdata,m_mbe,i_resp,i_rdata,d_resp,d_rdata,busy}
    vecs[0]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h40, 0, 4'hF, 0, 0, 0, 0, 1};
    vecs[2]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h40, 0, 4'hF, 0, 0, 0, 0, 1};
    vecs[3]  = '{1, 32'h40, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 0, 32'h40, 0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 32'h100, 32'h12345678, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h100, 32'h12345678, 4'h3, 32'hAAAA5555, 1,
                 0, 1, 32'h100, 32'h12345678, 4'h3, 0, 0, 1, 32'hAAAA5555, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 32'h100, 0, 4'hF, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 32'h200, 0, 4'hF, 0, 0,        1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 1, 0, 32'h200, 0, 4'hF, 32'h0BADF00D, 1,
                 1, 0, 32'h100, 0, 4'hF, 0, 0, 1, 32'h0BADF00D, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 32'h300, 32'h5A5A5A5A, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 1, 32'h300, 32'h5A5A5A5A, 4'hC, 32'h11, 1,
                 0, 1, 32'h300, 32'h5A5A5A5A, 4'hC, 0, 0, 1, 32'h11, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    drive_idle();
    rst = 1'b1;
    #2;
    check_all_zero("reset");
    check("reset.timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors: drive at negedge, sample 2 ns later.
    for (int v = 0; v < 15; v++) begin
      if (v != 0) @(negedge clk);
      bus.i_read  = vecs[v].i_read;
      bus.i_addr  = vecs[v].i_addr;
      bus.d_read  = vecs[v].d_read;
      bus.d_write = vecs[v].d_write;
      bus.d_addr  = vecs[v].d_addr;
      bus.d_wdata = vecs[v].d_wdata;
      bus.d_mbe   = vecs[v].d_mbe;
      bus.m_rdata = vecs[v].m_rdata;
      bus.m_resp  = vecs[v].m_resp;
      #2;
      check($sformatf("v%0d.m_read", v),  32'(bus.m_read),  32'(vecs[v].e_m_read));
      check($sformatf("v%0d.m_write", v), 32'(bus.m_write), 32'(vecs[v].e_m_write));
      check($sformatf("v%0d.m_addr", v),  bus.m_addr,       vecs[v].e_m_addr);
      check($sformatf("v%0d.m_wdata", v), bus.m_wdata,      vecs[v].e_m_wdata);
      check($sformatf("v%0d.m_mbe", v),   32'(bus.m_mbe),   32'(vecs[v].e_m_mbe));
      check($sformatf("v%0d.i_resp", v),  32'(bus.i_resp),  32'(vecs[v].e_i_resp));
      check($sformatf("v%0d.i_rdata", v), bus.i_rdata,      vecs[v].e_i_rdata);
      check($sformatf("v%0d.d_resp", v),  32'(bus.d_resp),  32'(vecs[v].e_d_resp));
      check($sformatf("v%0d.d_rdata", v), bus.d_rdata,      vecs[v].e_d_rdata);
      check($sformatf("v%0d.busy", v),    32'(busy),        32'(vecs[v].e_busy));
      check($sformatf("v%0d.timeout_err", v), 32'(timeout_err), 32'd0);
    end

    // Contention: both requesters held, memory answers every busy cycle.
    // Expected grant order D,D,D,D,I,D (fetch address 0x40, data 0x80).
    @(negedge clk);
    drive_idle();
    bus.i_read = 1'b1; bus.i_addr = 32'h40;
    bus.d_read = 1'b1; bus.d_addr = 32'h80; bus.d_mbe = 4'hF;
    bus.m_resp = 1'b1;
    #2;
    check("cont.idle0.busy", 32'(busy), 32'd0);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk); #2;
      check($sformatf("cont.g%0d.busy", g), 32'(busy), 32'd1);
      check($sformatf("cont.g%0d.m_addr", g), bus.m_addr, (g == 4) ? 32'h40 : 32'h80);
      check($sformatf("cont.g%0d.i_resp", g), 32'(bus.i_resp), (g == 4) ? 32'd1 : 32'd0);
      @(negedge clk); #2;
      check($sformatf("cont.g%0d.idle", g), 32'(busy), 32'd0);
    end
    drive_idle();

    // Async reset in the middle of a fetch, then regrant after release.
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_addr = 32'h44;
    @(negedge clk); #2;
    check("arst.pre.m_read", 32'(bus.m_read), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst.m_read", 32'(bus.m_read), 32'd0);
    check("arst.busy",   32'(busy),       32'd0);
    check("arst.m_addr", bus.m_addr,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("arst.rel.busy", 32'(busy), 32'd0);
    @(negedge clk); #2;
    check("arst.regrant.busy",   32'(busy),       32'd1);
    check("arst.regrant.m_read", 32'(bus.m_read), 32'd1);
    check("arst.regrant.m_addr", bus.m_addr,      32'h44);

    // Watchdog: memory withholds m_resp on the fetch just granted.
    repeat (4) @(negedge clk);
    #2;
    check("wdog.4cyc.err", 32'(timeout_err), 32'd0);
    @(negedge clk); #2;
    check("wdog.5cyc.err", 32'(timeout_err), 32'd1);
    check("wdog.5cyc.busy", 32'(busy), 32'd1);
    bus.m_resp = 1'b1; bus.m_rdata = 32'hCAFE0001; bus.i_read = 1'b0;
    #1;
    check("wdog.late.i_resp",  32'(bus.i_resp), 32'd1);
    check("wdog.late.i_rdata", bus.i_rdata,     32'hCAFE0001);
    @(negedge clk);
    drive_idle();
    #2;
    check("wdog.after.busy", 32'(busy), 32'd0);
    check("wdog.after.err",  32'(timeout_err), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    check("wdog.sticky.err", 32'(timeout_err), 32'd1);
    rst = 1'b1;
    #1;
    check("wdog.rst.err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
